// File: rtl/bcd_sseg_mux_pkg.sv
// Shared types and active-low segment/anode codes for the BCD seven-segment display driver.
// Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment.
package bcd_sseg_mux_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_sel_e;

    localparam logic [6:0] SSEG_0    = 7'h01;
    localparam logic [6:0] SSEG_1    = 7'h4F;
    localparam logic [6:0] SSEG_2    = 7'h12;
    localparam logic [6:0] SSEG_3    = 7'h06;
    localparam logic [6:0] SSEG_4    = 7'h4C;
    localparam logic [6:0] SSEG_5    = 7'h24;
    localparam logic [6:0] SSEG_6    = 7'h20;
    localparam logic [6:0] SSEG_7    = 7'h0F;
    localparam logic [6:0] SSEG_8    = 7'h00;
    localparam logic [6:0] SSEG_9    = 7'h04;
    localparam logic [6:0] SSEG_DASH = 7'h7E;

    localparam logic [7:0] SSEG_OFF  = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    function automatic logic [3:0] anodeFor(input digit_sel_e sel);
        return AN_OFF ^ (4'b0001 << sel);
    endfunction

endpackage

// File: rtl/bcd_sseg_mux_if.sv
// Digit/control inputs and display outputs of the multiplexed seven-segment driver.
// The master drives the digits and strobes; the slave (the driver) drives the display pins.
interface bcd_sseg_mux_if;
    import bcd_sseg_mux_pkg::*;

    logic       load;
    bcd_t       bcd3;
    bcd_t       bcd2;
    bcd_t       bcd1;
    bcd_t       bcd0;
    logic [3:0] dp_in;
    logic       blank;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       valid;

    modport master (
        output load, bcd3, bcd2, bcd1, bcd0, dp_in, blank,
        input  an, sseg, valid
    );

    modport slave (
        input  load, bcd3, bcd2, bcd1, bcd0, dp_in, blank,
        output an, sseg, valid
    );

endinterface

// File: rtl/bcd_sseg_mux_bcd_to_sseg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes 10..15 are not decimal digits and are shown as a dash so bad data is visible.
module bcd_to_sseg
    import bcd_sseg_mux_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SSEG_0;
            4'd1:    seg_o = SSEG_1;
            4'd2:    seg_o = SSEG_2;
            4'd3:    seg_o = SSEG_3;
            4'd4:    seg_o = SSEG_4;
            4'd5:    seg_o = SSEG_5;
            4'd6:    seg_o = SSEG_6;
            4'd7:    seg_o = SSEG_7;
            4'd8:    seg_o = SSEG_8;
            4'd9:    seg_o = SSEG_9;
            default: seg_o = SSEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_sseg_mux.sv
// Latches four BCD digits on load and time-multiplexes them onto a 4-digit common-anode
// display with leading-zero blanking, per-digit decimal points and a global blank.
module bcd_sseg_mux
    import bcd_sseg_mux_pkg::*;
#(
    parameter int REFRESH_BITS = 18,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_sseg_mux_if.slave        bus
);

    localparam logic [REFRESH_BITS-1:0] CNT_ONE = 1;

    logic [REFRESH_BITS-1:0] scanCnt_q;
    bcd_t [3:0]              digits_q;
    logic [3:0]              dp_q;
    logic                    valid_q;
    logic [3:0]              an_q;
    logic [7:0]              sseg_q;

    digit_sel_e              sel;
    bcd_t                    curDigit;
    logic [6:0]              curSeg;
    logic                    lzOff;
    logic                    digitOn;
    logic [3:0]              an_d;
    logic [7:0]              sseg_d;

    assign sel      = digit_sel_e'(scanCnt_q[REFRESH_BITS-1 -: 2]);
    assign curDigit = digits_q[sel];

    bcd_to_sseg u_decode (
        .bcd_i (curDigit),
        .seg_o (curSeg)
    );

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        lzOff = 1'b0;
        if (BLANK_LZ && sel != DIG0) begin
            lzOff = 1'b1;
            for (int k = 1; k < 4; k++) begin
                if (k >= int'(sel) && digits_q[k] != 4'd0) begin
                    lzOff = 1'b0;
                end
            end
        end
        digitOn = valid_q && !bus.blank && !lzOff;
        an_d    = AN_OFF;
        sseg_d  = SSEG_OFF;
        if (digitOn) begin
            an_d   = anodeFor(sel);
            sseg_d = {~dp_q[sel], curSeg};
        end
    end

    // Anode and segment pins change together from registers, so at most one anode is ever low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scanCnt_q <= '0;
            digits_q  <= '0;
            dp_q      <= '0;
            valid_q   <= 1'b0;
            an_q      <= AN_OFF;
            sseg_q    <= SSEG_OFF;
        end else begin
            scanCnt_q <= scanCnt_q + CNT_ONE;
            an_q      <= an_d;
            sseg_q    <= sseg_d;
            if (bus.load) begin
                digits_q <= {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
                dp_q     <= bus.dp_in;
                valid_q  <= 1'b1;
            end
        end
    end

    assign bus.an    = an_q;
    assign bus.sseg  = sseg_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_bcd_sseg_mux.sv
// Self-checking bench for bcd_sseg_mux: a cycle model checks two instances (leading-zero
// blanking on and off) every cycle, with literal checks pinning the expected display codes.
module tb_bcd_sseg_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic       blank;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic [3:0] dpIn;
    logic       checkOn = 1'b0;

    int checks = 0;
    int errors = 0;

    bcd_sseg_mux_if busA ();
    bcd_sseg_mux_if busB ();

    assign busA.load  = load;
    assign busA.bcd3  = bcd3;
    assign busA.bcd2  = bcd2;
    assign busA.bcd1  = bcd1;
    assign busA.bcd0  = bcd0;
    assign busA.dp_in = dpIn;
    assign busA.blank = blank;
    assign busB.load  = load;
    assign busB.bcd3  = bcd3;
    assign busB.bcd2  = bcd2;
    assign busB.bcd1  = bcd1;
    assign busB.bcd0  = bcd0;
    assign busB.dp_in = dpIn;
    assign busB.blank = blank;

    bcd_sseg_mux #(.REFRESH_BITS(4), .BLANK_LZ(1'b1)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    bcd_sseg_mux #(.REFRESH_BITS(4), .BLANK_LZ(1'b0)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    always #5 clk = ~clk;

    logic [6:0]  segTab [16];
    int          cyc;
    int          mCnt;
    int          slot;
    logic [15:0] mDigits;
    logic [3:0]  mDp;
    logic        mValid;
    logic        offA, offB;
    logic [3:0]  curD;
    logic [3:0]  expAnA, expAnB;
    logic [7:0]  expSsegA, expSsegB;

    initial begin
        segTab[0] = 7'h01; segTab[1] = 7'h4F; segTab[2] = 7'h12; segTab[3] = 7'h06;
        segTab[4] = 7'h4C; segTab[5] = 7'h24; segTab[6] = 7'h20; segTab[7] = 7'h0F;
        segTab[8] = 7'h00; segTab[9] = 7'h04;
        for (int i = 10; i < 16; i++) segTab[i] = 7'h7E;
    end

    // Model: the outputs after an edge show the digit picked by the count before that edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc = 0; mCnt = 0; mDigits = '0; mDp = '0; mValid = 1'b0;
            expAnA = 4'hF; expAnB = 4'hF; expSsegA = 8'hFF; expSsegB = 8'hFF;
        end else begin
            slot = (mCnt / 4) % 4;
            curD = mDigits[4*slot +: 4];
            offB = !mValid || blank;
            offA = offB || (slot != 0 && (mDigits >> (4*slot)) == 16'd0);
            expAnA   = offA ? 4'hF  : 4'hF ^ (4'b0001 << slot);
            expAnB   = offB ? 4'hF  : 4'hF ^ (4'b0001 << slot);
            expSsegA = offA ? 8'hFF : {~mDp[slot], segTab[curD]};
            expSsegB = offB ? 8'hFF : {~mDp[slot], segTab[curD]};
            mCnt = (mCnt + 1) % 16;
            cyc++;
            if (load) begin
                mDigits = {bcd3, bcd2, bcd1, bcd0};
                mDp     = dpIn;
                mValid  = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("anA",     {4'h0, busA.an}, {4'h0, expAnA});
            checkOutput("ssegA",   busA.sseg,       expSsegA);
            checkOutput("validA",  {7'h0, busA.valid}, {7'h0, mValid});
            checkOutput("anB",     {4'h0, busB.an}, {4'h0, expAnB});
            checkOutput("ssegB",   busB.sseg,       expSsegB);
            checkOutput("oneHotA", {7'h0, $countones(~busA.an) <= 1}, 8'h01);
            checkOutput("oneHotB", {7'h0, $countones(~busB.an) <= 1}, 8'h01);
        end
    end

    task automatic applyStimulus(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                                 input logic [3:0] d0, input logic [3:0] dp, input logic bl);
        load = 1'b1; bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0; dpIn = dp; blank = bl;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic waitOutSlot(input int s);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((((cyc - 1) & 15) != 4*s) && n < 40);
        if (n >= 40) begin
            checks++;
            errors++;
            $display("[TB] FAIL slotWait actual=timeout required=slot%0d", s);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; blank = 1'b0;
        bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0; dpIn = 4'd0;
        repeat (3) @(negedge clk);
        checkOn = 1'b1;
        checkOutput("rstAn",    {4'h0, busA.an}, 8'h0F);
        checkOutput("rstSseg",  busA.sseg, 8'hFF);
        checkOutput("rstValid", {7'h0, busA.valid}, 8'h00);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
        waitOutSlot(0);
        checkOutput("t2An0",   {4'h0, busA.an}, 8'h0E);
        checkOutput("t2Sseg0", busA.sseg, 8'hCC);
        checkOutput("t2Valid", {7'h0, busA.valid}, 8'h01);
        waitOutSlot(3);
        checkOutput("t2An3",   {4'h0, busA.an}, 8'h07);
        checkOutput("t2Sseg3", busA.sseg, 8'hCF);

        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midRstAn",    {4'h0, busA.an}, 8'h0F);
        checkOutput("midRstSseg",  busA.sseg, 8'hFF);
        checkOutput("midRstValid", {7'h0, busA.valid}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(4'd0, 4'd0, 4'd0, 4'd7, 4'b0000, 1'b0);
        waitOutSlot(0);
        checkOutput("t3An0",    {4'h0, busA.an}, 8'h0E);
        checkOutput("t3Sseg0",  busA.sseg, 8'h8F);
        waitOutSlot(1);
        checkOutput("t3LzAn1",  {4'h0, busA.an}, 8'h0F);
        checkOutput("t3NoLzB1", busB.sseg, 8'h81);
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0);
        waitOutSlot(0);
        checkOutput("t3Zero0",  busA.sseg, 8'h81);
        waitOutSlot(2);
        checkOutput("t3LzAn2",  {4'h0, busA.an}, 8'h0F);
        checkOutput("t3NoLzA2", {4'h0, busB.an}, 8'h0B);

        applyStimulus(4'd0, 4'd0, 4'hC, 4'd5, 4'b0001, 1'b0);
        waitOutSlot(0);
        checkOutput("t4Dp0",   busA.sseg, 8'h24);
        waitOutSlot(1);
        checkOutput("t4Dash1", busA.sseg, 8'hFE);
        waitOutSlot(3);
        checkOutput("t4LzAn3", {4'h0, busA.an}, 8'h0F);

        applyStimulus(4'd9, 4'd8, 4'd7, 4'd6, 4'b0000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            checkOutput("t5BlankAn", {4'h0, busA.an}, 8'h0F);
            @(negedge clk);
        end
        blank = 1'b0;
        waitOutSlot(3);
        checkOutput("t5Sseg3", busA.sseg, 8'h84);
        waitOutSlot(0);
        applyStimulus(4'd9, 4'd8, 4'd7, 4'd2, 4'b0000, 1'b0);
        checkOutput("t5OldDig", busA.sseg, 8'hA0);
        @(negedge clk);
        checkOutput("t5NewDig", busA.sseg, 8'h92);

        for (int i = 0; i < 400; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            blank = ($urandom_range(0, 9) == 0);
            bcd3  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
            bcd2  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
            bcd1  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
            bcd0  = 4'($urandom_range(0, 15));
            dpIn  = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        load = 1'b0;
        blank = 1'b0;
        repeat (4) @(negedge clk);

        checkOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
